// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU operation
// classes and the WB/MEM/EX control bundle latched by ID/EX.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       branch;
        logic       memRead;
        logic       memWrite;
        logic       regDest;
        logic       aluSrc;
        logic [1:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with
// write-through, one write port, asynchronous clear.
// Ports: clock_i, reset_i, raddr1_i/raddr2_i -> rdata1_o/rdata2_o,
//        we_i, waddr_i, wdata_i (write port).
module register_file (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];
    logic        wr_en;

    // r0 is hard-wired; writes during reset are dropped.
    assign wr_en = we_i && (waddr_i != 5'd0) && !reset_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass the in-flight write so WB and ID can share a cycle.
    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != 5'd0) begin
            if (wr_en && (waddr_i == raddr1_i)) begin
                rdata1_o = wdata_i;
            end else begin
                rdata1_o = regs_q[raddr1_i];
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != 5'd0) begin
            if (wr_en && (waddr_i == raddr2_i)) begin
                rdata2_o = wdata_i;
            end else begin
                rdata2_o = regs_q[raddr2_i];
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, control decode,
// sign extension and load-use hazard detection.
// Ports: clock/reset; instruction, pcPlus4 from IF/ID; wb* write-back
//        port; exMemRead/exRt from ID/EX; operands, fields, control
//        bundle, pcWrite/ifIdWrite stall controls, illegalInstr.
module id_stage
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] pcPlus4,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbWriteReg,
    input  logic [31:0] wbWriteData,
    input  logic        exMemRead,
    input  logic [4:0]  exRt,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] signExtendWire,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] outPcPlus4,
    output logic        regWrite,
    output logic        memToReg,
    output logic        branch,
    output logic        memRead,
    output logic        memWrite,
    output logic        regDest,
    output logic        aluSrc,
    output logic [1:0]  aluOp,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        illegalInstr
);

    logic [5:0] opcode;
    ctrl_t      ctrl_dec;
    ctrl_t      ctrl_out;
    logic       uses_rt;
    logic       illegal_dec;
    logic       stall;

    assign opcode         = instruction[31:26];
    assign rs             = instruction[25:21];
    assign rt             = instruction[20:16];
    assign rd             = instruction[15:11];
    assign signExtendWire = {{16{instruction[15]}}, instruction[15:0]};
    assign outPcPlus4     = pcPlus4;

    register_file u_rf (
        .clock_i  (clock),
        .reset_i  (reset),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .we_i     (wbRegWrite),
        .waddr_i  (wbWriteReg),
        .wdata_i  (wbWriteData),
        .rdata1_o (readData1),
        .rdata2_o (readData2)
    );

    always_comb begin
        ctrl_dec    = CTRL_NONE;
        uses_rt     = 1'b0;
        illegal_dec = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                ctrl_dec.regDest  = 1'b1;
                ctrl_dec.regWrite = 1'b1;
                ctrl_dec.aluOp    = ALUOP_FUNCT;
                uses_rt           = 1'b1;
            end
            (opcode == OP_LW): begin
                ctrl_dec.aluSrc   = 1'b1;
                ctrl_dec.memToReg = 1'b1;
                ctrl_dec.regWrite = 1'b1;
                ctrl_dec.memRead  = 1'b1;
                ctrl_dec.aluOp    = ALUOP_ADD;
            end
            (opcode == OP_SW): begin
                ctrl_dec.aluSrc   = 1'b1;
                ctrl_dec.memWrite = 1'b1;
                ctrl_dec.aluOp    = ALUOP_ADD;
                uses_rt           = 1'b1;
            end
            (opcode == OP_BEQ): begin
                ctrl_dec.branch = 1'b1;
                ctrl_dec.aluOp  = ALUOP_SUB;
                uses_rt         = 1'b1;
            end
            (opcode == OP_ADDI): begin
                ctrl_dec.aluSrc   = 1'b1;
                ctrl_dec.regWrite = 1'b1;
                ctrl_dec.aluOp    = ALUOP_ADD;
            end
            default: begin
                illegal_dec = 1'b1;
            end
        endcase
    end

    // rt only matters for a load-use hit when this instruction
    // actually reads it (lw/addi overwrite rt instead).
    assign stall = !reset && exMemRead && (exRt != 5'd0) &&
                   ((exRt == rs) || (uses_rt && (exRt == rt)));

    // A stalled instruction enters ID/EX as a bubble.
    assign ctrl_out     = (reset || stall) ? CTRL_NONE : ctrl_dec;
    assign pcWrite      = !stall;
    assign ifIdWrite    = !stall;
    assign illegalInstr = illegal_dec && !reset;

    assign regWrite = ctrl_out.regWrite;
    assign memToReg = ctrl_out.memToReg;
    assign branch   = ctrl_out.branch;
    assign memRead  = ctrl_out.memRead;
    assign memWrite = ctrl_out.memWrite;
    assign regDest  = ctrl_out.regDest;
    assign aluSrc   = ctrl_out.aluSrc;
    assign aluOp    = ctrl_out.aluOp;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with a queue scoreboard
// drained by an independent monitor process.
module tb_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pcPlus4;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic [31:0] readData1, readData2, signExtendWire, outPcPlus4;
    logic [4:0]  rs, rt, rd;
    logic        regWrite, memToReg, branch, memRead, memWrite;
    logic        regDest, aluSrc, pcWrite, ifIdWrite, illegalInstr;
    logic [1:0]  aluOp;

    id_stage dut (
        .clock          (clock),
        .reset          (reset),
        .instruction    (instruction),
        .pcPlus4        (pcPlus4),
        .wbRegWrite     (wbRegWrite),
        .wbWriteReg     (wbWriteReg),
        .wbWriteData    (wbWriteData),
        .exMemRead      (exMemRead),
        .exRt           (exRt),
        .readData1      (readData1),
        .readData2      (readData2),
        .signExtendWire (signExtendWire),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .outPcPlus4     (outPcPlus4),
        .regWrite       (regWrite),
        .memToReg       (memToReg),
        .branch         (branch),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .regDest        (regDest),
        .aluSrc         (aluSrc),
        .aluOp          (aluOp),
        .pcWrite        (pcWrite),
        .ifIdWrite      (ifIdWrite),
        .illegalInstr   (illegalInstr)
    );

    always #5 clock = ~clock;

    // {regWrite,memToReg,branch,memRead,memWrite,regDest,aluSrc,aluOp}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_R    = 9'b100001010;
    localparam logic [8:0] C_LW   = 9'b110100100;
    localparam logic [8:0] C_SW   = 9'b000010100;
    localparam logic [8:0] C_BEQ  = 9'b001000001;
    localparam logic [8:0] C_ADDI = 9'b100000100;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] pc4;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [8:0]  ctrl;
        logic        stall;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] sext,
                       input logic [8:0] ctrl, input logic stall,
                       input logic ill);
        exp_t e;
        #1;
        e.name  = name;
        e.rd1   = rd1;
        e.rd2   = rd2;
        e.sext  = sext;
        e.pc4   = pcPlus4;
        e.f_rs  = instruction[25:21];
        e.f_rt  = instruction[20:16];
        e.f_rd  = instruction[15:11];
        e.ctrl  = ctrl;
        e.stall = stall;
        e.ill   = ill;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the live outputs against each queued entry.
    initial begin
        exp_t       e;
        logic [8:0] act_ctrl;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            act_ctrl = {regWrite, memToReg, branch, memRead, memWrite,
                        regDest, aluSrc, aluOp};
            n_vec++;
            if (readData1 !== e.rd1 || readData2 !== e.rd2 ||
                signExtendWire !== e.sext || outPcPlus4 !== e.pc4 ||
                rs !== e.f_rs || rt !== e.f_rt || rd !== e.f_rd ||
                act_ctrl !== e.ctrl || pcWrite !== !e.stall ||
                ifIdWrite !== !e.stall || illegalInstr !== e.ill) begin
                n_miss++;
                $display("FAIL %s: got rd1=%h rd2=%h sext=%h pc4=%h f=%0d/%0d/%0d ctrl=%b pcw=%b ifw=%b ill=%b want rd1=%h rd2=%h sext=%h pc4=%h f=%0d/%0d/%0d ctrl=%b pcw=%b ifw=%b ill=%b",
                         e.name, readData1, readData2, signExtendWire,
                         outPcPlus4, rs, rt, rd, act_ctrl, pcWrite,
                         ifIdWrite, illegalInstr, e.rd1, e.rd2, e.sext,
                         e.pc4, e.f_rs, e.f_rt, e.f_rd, e.ctrl, !e.stall,
                         !e.stall, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v1, v2;
        reset       = 1'b1;
        instruction = 32'h00A01820;
        pcPlus4     = 32'h0000_0004;
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd5;
        wbWriteData = 32'h0000_AAAA;
        exMemRead   = 1'b1;
        exRt        = 5'd5;
        chk("rst_hold", 32'h0, 32'h0, 32'h1820, C_NONE, 1'b0, 1'b0);
        @(negedge clock);
        chk("rst_wr_ign", 32'h0, 32'h0, 32'h1820, C_NONE, 1'b0, 1'b0);
        @(negedge clock);
        reset      = 1'b0;
        wbRegWrite = 1'b0;
        exMemRead  = 1'b0;
        pcPlus4    = 32'h0000_0008;
        chk("post_rst", 32'h0, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);

        wbRegWrite  = 1'b1;
        wbWriteData = 32'hDEAD_BEEF;
        chk("wt_r5", 32'hDEAD_BEEF, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);
        @(negedge clock);
        wbRegWrite = 1'b0;
        chk("add_r5", 32'hDEAD_BEEF, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);

        instruction = 32'h0000_1820;
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd0;
        wbWriteData = 32'h0000_1234;
        chk("wt_r0", 32'h0, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);
        @(negedge clock);
        wbRegWrite = 1'b0;
        chk("r0_zero", 32'h0, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);

        instruction = 32'h00E5_1020;
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd7;
        wbWriteData = 32'h0000_0055;
        chk("wt_r7", 32'h55, 32'hDEAD_BEEF, 32'h1020, C_R, 1'b0, 1'b0);
        @(negedge clock);
        wbRegWrite = 1'b0;
        chk("r7_stored", 32'h55, 32'hDEAD_BEEF, 32'h1020, C_R, 1'b0, 1'b0);

        instruction = 32'hAD28_0004;
        exMemRead   = 1'b1;
        exRt        = 5'd8;
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd8;
        wbWriteData = 32'h0000_0088;
        chk("lu_sw_stall", 32'h0, 32'h88, 32'h4, C_NONE, 1'b1, 1'b0);
        @(negedge clock);
        exMemRead  = 1'b0;
        wbRegWrite = 1'b0;
        chk("lu_release", 32'h0, 32'h88, 32'h4, C_SW, 1'b0, 1'b0);
        exMemRead = 1'b1;
        exRt      = 5'd0;
        chk("exrt_zero", 32'h0, 32'h88, 32'h4, C_SW, 1'b0, 1'b0);

        instruction = 32'h8D28_FFFC;
        exRt        = 5'd8;
        chk("lw_rt_nohaz", 32'h0, 32'h88, 32'hFFFF_FFFC, C_LW, 1'b0, 1'b0);
        exRt = 5'd9;
        chk("lw_rs_haz", 32'h0, 32'h88, 32'hFFFF_FFFC, C_NONE, 1'b1, 1'b0);
        exMemRead = 1'b0;

        instruction = 32'hFC00_0000;
        chk("illegal", 32'h0, 32'h0, 32'h0, C_NONE, 1'b0, 1'b1);
        instruction = 32'h10A8_FFFF;
        chk("beq", 32'hDEAD_BEEF, 32'h88, 32'hFFFF_FFFF, C_BEQ, 1'b0, 1'b0);
        exMemRead = 1'b1;
        exRt      = 5'd8;
        chk("beq_haz", 32'hDEAD_BEEF, 32'h88, 32'hFFFF_FFFF, C_NONE,
            1'b1, 1'b0);
        exMemRead = 1'b0;
        instruction = 32'h20A4_7FFF;
        chk("addi", 32'hDEAD_BEEF, 32'h0, 32'h0000_7FFF, C_ADDI, 1'b0, 1'b0);
        instruction = 32'h0000_0000;
        chk("nop", 32'h0, 32'h0, 32'h0, C_R, 1'b0, 1'b0);

        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            wbRegWrite  = 1'b1;
            wbWriteReg  = 5'(i);
            wbWriteData = 32'h1000_0000 + i;
        end
        @(negedge clock);
        wbRegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            instruction = {6'b0, 5'(i), 5'(31 - i), 16'h1820};
            v1 = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            v2 = (i == 31) ? 32'h0 : 32'h1000_0000 + (31 - i);
            chk("fill_rd", v1, v2, 32'h1820, C_R, 1'b0, 1'b0);
        end

        @(negedge clock);
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd9;
        wbWriteData = 32'h0000_0099;
        exMemRead   = 1'b1;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            instruction = {6'b0, 5'(i), 5'(31 - i), 16'h1820};
            exRt        = 5'(i);
            chk("rst_clear", 32'h0, 32'h0, 32'h1820, C_NONE, 1'b0, 1'b0);
        end
        instruction = 32'hFC00_0000;
        chk("rst_illegal", 32'h0, 32'h0, 32'h0, C_NONE, 1'b0, 1'b0);
        @(negedge clock);
        reset       = 1'b0;
        wbRegWrite  = 1'b0;
        exMemRead   = 1'b0;
        instruction = 32'h013F_1820;
        chk("post_rst2", 32'h0, 32'h0, 32'h1820, C_R, 1'b0, 1'b0);

        #5;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
